// File: rtl/controle_inimigo_if.sv
// Bus between the enemy controller and its game-side neighbours.
// Inputs: frame_tick/ativo/acerto/acerto_nave.
// Outputs: enemy and enemy-ball coordinates plus status.
// The game side (or a bench) takes the master modport.
// The controller takes the slave modport.
interface controle_inimigo_if;
   logic       frame_tick;
   logic       ativo;
   logic       acerto;
   logic       acerto_nave;
   logic [9:0] x_inimigo;
   logic [9:0] y_inimigo;
   logic       inimigo_vivo;
   logic [9:0] x_bola_inimiga;
   logic [9:0] y_bola_inimiga;
   logic       tiro_ativo;
   logic       invadiu;
   logic [7:0] pontos;

   modport master (
      output frame_tick, ativo, acerto, acerto_nave,
      input  x_inimigo, y_inimigo, inimigo_vivo,
      input  x_bola_inimiga, y_bola_inimiga, tiro_ativo, invadiu, pontos
   );

   modport slave (
      input  frame_tick, ativo, acerto, acerto_nave,
      output x_inimigo, y_inimigo, inimigo_vivo,
      output x_bola_inimiga, y_bola_inimiga, tiro_ativo, invadiu, pontos
   );
endinterface

// File: rtl/controle_inimigo.sv
// Frame-rate scheduler for the enemy sprite and its ball.
// It handles march, edge bounce and descent, kill and respawn, and shot spawn and travel.
// Optional macro ACELERACAO_EN: when defined, each kill shortens the move divider by one frame.
// The divider never drops below 1 frame.
// All outputs come straight from registers.
module controle_inimigo #(
   parameter int LARGURA_TELA   = 640,
   parameter int ALTURA_TELA    = 480,
   parameter int LARGURA_SPRITE = 33,
   parameter int ALTURA_SPRITE  = 24,
   parameter int X_INICIAL      = 0,
   parameter int Y_INICIAL      = 32,
   parameter int PASSO_X        = 4,
   parameter int PASSO_Y        = 16,
   parameter int DIV_MOV        = 8,
   parameter int LIMITE_Y       = 400,
   parameter int RESPAWN        = 30,
   parameter int COOLDOWN_TIRO  = 60,
   parameter int VEL_TIRO       = 4
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   controle_inimigo_if.slave    bus
);

   localparam int DW = $clog2(DIV_MOV + 1);
   localparam int RW = $clog2(RESPAWN + 1);
   localparam int CW = $clog2(COOLDOWN_TIRO + 1);

   typedef enum logic [1:0] {PARADO, MOVENDO, MORTO, INVADIU} estado_t;

   estado_t         estado_q;
   logic [9:0]      x_q, y_q, xb_q, yb_q;
   logic            dir_q;          // 1 = moving right
   logic            vivo_q, tiro_q, invadiu_q;
   logic [7:0]      pontos_q;
   logic [DW-1:0]   div_q;
   logic [RW-1:0]   resp_q;
   logic [CW-1:0]   cd_q;
   logic [DW-1:0]   div_eff;

`ifdef ACELERACAO_EN
   logic [DW-1:0]   div_eff_q;
   assign div_eff = div_eff_q;
`else
   assign div_eff = DW'(DIV_MOV);
`endif

   logic            passo_d, na_borda_d, invade_d, spawn_d, tiro_roda_d, invadindo_d;
   logic [DW-1:0]   div_d;
   logic [9:0]      x_d;
   logic [10:0]     y_desc_d, yb_prox_d;

   // Step timing, edge detection and shot conditions for the current cycle.
   always_comb begin
      passo_d     = (div_q >= div_eff - 1'b1);
      div_d       = passo_d ? '0 : div_q + 1'b1;
      na_borda_d  = dir_q ? (({1'b0, x_q} + 11'(PASSO_X) + 11'(LARGURA_SPRITE)) > 11'(LARGURA_TELA))
                          : (x_q < 10'(PASSO_X));
      x_d         = dir_q ? x_q + 10'(PASSO_X) : x_q - 10'(PASSO_X);
      y_desc_d    = {1'b0, y_q} + 11'(PASSO_Y);
      invade_d    = (y_desc_d >= 11'(LIMITE_Y));
      // Descent that crosses the limit on this tick; suppresses any shot.
      invadindo_d = (estado_q == MOVENDO) && bus.ativo && !bus.acerto && bus.frame_tick &&
                    passo_d && na_borda_d && invade_d;
      tiro_roda_d = bus.ativo && ((estado_q == MOVENDO) || (estado_q == MORTO));
      // The spawn uses the pre-step enemy position when a step lands on the same tick.
      spawn_d     = tiro_roda_d && bus.frame_tick && (estado_q == MOVENDO) &&
                    (cd_q == '0) && vivo_q && !tiro_q;
      yb_prox_d   = {1'b0, yb_q} + 11'(VEL_TIRO);
   end

   // Enemy FSM plus shot state; later assignments in this block take priority.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         estado_q  <= PARADO;
         x_q       <= 10'(X_INICIAL);
         y_q       <= 10'(Y_INICIAL);
         dir_q     <= 1'b1;
         vivo_q    <= 1'b1;
         xb_q      <= '0;
         yb_q      <= '0;
         tiro_q    <= 1'b0;
         invadiu_q <= 1'b0;
         pontos_q  <= '0;
         div_q     <= '0;
         resp_q    <= '0;
         cd_q      <= CW'(COOLDOWN_TIRO);
`ifdef ACELERACAO_EN
         div_eff_q <= DW'(DIV_MOV);
`endif
      end else begin
         case (estado_q)
            PARADO: begin
               if (bus.ativo) estado_q <= MOVENDO;
            end
            MOVENDO: begin
               if (!bus.ativo) begin
                  estado_q <= PARADO;
               end else if (bus.acerto) begin
                  vivo_q   <= 1'b0;
                  resp_q   <= RW'(RESPAWN);
                  estado_q <= MORTO;
                  if (pontos_q != 8'hFF) pontos_q <= pontos_q + 8'd1;
`ifdef ACELERACAO_EN
                  if (div_eff_q > DW'(1)) div_eff_q <= div_eff_q - 1'b1;
`endif
               end else if (bus.frame_tick) begin
                  div_q <= div_d;
                  if (passo_d) begin
                     if (na_borda_d) begin
                        y_q   <= y_desc_d[9:0];
                        dir_q <= ~dir_q;
                        if (invade_d) begin
                           estado_q  <= INVADIU;
                           invadiu_q <= 1'b1;
                        end
                     end else begin
                        x_q <= x_d;
                     end
                  end
               end
            end
            MORTO: begin
               if (bus.ativo && bus.frame_tick) begin
                  if (resp_q <= RW'(1)) begin
                     resp_q   <= '0;
                     x_q      <= 10'(X_INICIAL);
                     y_q      <= 10'(Y_INICIAL);
                     dir_q    <= 1'b1;
                     div_q    <= '0;
                     vivo_q   <= 1'b1;
                     estado_q <= MOVENDO;
                  end else begin
                     resp_q <= resp_q - 1'b1;
                  end
               end
            end
            default: ;  // INVADIU is terminal
         endcase

         if (tiro_roda_d) begin
            if (bus.frame_tick) begin
               if (spawn_d) begin
                  cd_q   <= CW'(COOLDOWN_TIRO);
                  xb_q   <= x_q + 10'(LARGURA_SPRITE / 2);
                  yb_q   <= y_q + 10'(ALTURA_SPRITE);
                  tiro_q <= 1'b1;
               end else begin
                  if (cd_q != '0) cd_q <= cd_q - 1'b1;
                  if (tiro_q) begin
                     if (yb_prox_d >= 11'(ALTURA_TELA)) tiro_q <= 1'b0;
                     else                              yb_q   <= yb_prox_d[9:0];
                  end
               end
            end
            if (bus.acerto_nave && tiro_q) tiro_q <= 1'b0;
         end

         if (invadindo_d) tiro_q <= 1'b0;
      end
   end

   assign bus.x_inimigo      = x_q;
   assign bus.y_inimigo      = y_q;
   assign bus.inimigo_vivo   = vivo_q;
   assign bus.x_bola_inimiga = xb_q;
   assign bus.y_bola_inimiga = yb_q;
   assign bus.tiro_ativo     = tiro_q;
   assign bus.invadiu        = invadiu_q;
   assign bus.pontos         = pontos_q;

endmodule

// File: tb/tb_controle_inimigo.sv
// Scoreboard bench for controle_inimigo.
// The stimulus side pushes hand-computed expectations tagged with the cycle they must appear in.
// A negedge monitor pops and compares them against the DUT outputs.
module tb_controle_inimigo;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   localparam int S_X = 0, S_Y = 1, S_VIVO = 2, S_XB = 3, S_YB = 4, S_TIRO = 5, S_INV = 6, S_PTS = 7;

   typedef struct {
      int    c;
      int    sel;
      int    v;
      string nm;
   } exp_t;

   exp_t q[$];

   controle_inimigo_if bus_if ();

   controle_inimigo dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int obs(input int sel);
      case (sel)
         S_X:     return int'(bus_if.x_inimigo);
         S_Y:     return int'(bus_if.y_inimigo);
         S_VIVO:  return int'(bus_if.inimigo_vivo);
         S_XB:    return int'(bus_if.x_bola_inimiga);
         S_YB:    return int'(bus_if.y_bola_inimiga);
         S_TIRO:  return int'(bus_if.tiro_ativo);
         S_INV:   return int'(bus_if.invadiu);
         default: return int'(bus_if.pontos);
      endcase
   endfunction

   // Monitor: compare every expectation due at this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].c <= cyc) begin
         exp_t e;
         int   got;
         e   = q.pop_front();
         got = obs(e.sel);
         tests++;
         if (got != e.v) begin
            fails++;
            $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", e.nm, cyc, got, e.v);
         end
      end
   end

   // Expectation for the cycle after the inputs just driven.
   task automatic expect_v(input string nm, input int sel, input int v);
      exp_t e;
      e.c = cyc + 1; e.sel = sel; e.v = v; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic step(input logic t, input logic hit, input logic nave);
      @(posedge clk);
      #1;
      bus_if.frame_tick  = t;
      bus_if.acerto      = hit;
      bus_if.acerto_nave = nave;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus_if.ativo = 1'b0;
      bus_if.frame_tick = 1'b0; bus_if.acerto = 1'b0; bus_if.acerto_nave = 1'b0;
      step(0, 0, 0);
      step(0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout cyc=%0d got=running want=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      bus_if.ativo = 1'b0;
      bus_if.frame_tick = 1'b0; bus_if.acerto = 1'b0; bus_if.acerto_nave = 1'b0;

      // Reset state
      do_reset();
      expect_v("rst_x", S_X, 0);     expect_v("rst_y", S_Y, 32);
      expect_v("rst_vivo", S_VIVO, 1); expect_v("rst_tiro", S_TIRO, 0);
      expect_v("rst_inv", S_INV, 0); expect_v("rst_pts", S_PTS, 0);
      expect_v("rst_xb", S_XB, 0);   expect_v("rst_yb", S_YB, 0);
      step(0, 0, 0);
      reset = 1'b0;
      // PARADO ignores ticks
      for (int i = 0; i < 10; i++) step(1, 0, 0);
      expect_v("parado_x", S_X, 0);
      step(0, 0, 0);
      bus_if.ativo = 1'b1;

      // March, shots, pause and edge bounce
      for (int t = 1; t <= 1224; t++) begin
         step(1, 0, 0);
         case (t)
            7:    expect_v("march_x7", S_X, 0);
            8:    begin expect_v("march_x8", S_X, 4); expect_v("march_y8", S_Y, 32); end
            60:   expect_v("cd_tiro60", S_TIRO, 0);
            61:   begin expect_v("spawn_tiro", S_TIRO, 1); expect_v("spawn_xb", S_XB, 44);
                        expect_v("spawn_yb", S_YB, 56); end
            100:  begin
                     expect_v("pre_pause_x", S_X, 48); expect_v("pre_pause_yb", S_YB, 212);
                     step(0, 0, 0);
                     bus_if.ativo = 1'b0;
                     for (int i = 0; i < 20; i++) step(1, 0, 0);
                     expect_v("pause_x", S_X, 48);    expect_v("pause_y", S_Y, 32);
                     expect_v("pause_xb", S_XB, 44);  expect_v("pause_yb", S_YB, 212);
                     expect_v("pause_tiro", S_TIRO, 1);
                     step(0, 0, 0);
                     bus_if.ativo = 1'b1;
                  end
            101:  expect_v("resume_yb", S_YB, 216);
            103:  expect_v("resume_x103", S_X, 48);
            104:  expect_v("resume_x104", S_X, 52);
            166:  begin expect_v("travel_yb166", S_YB, 476); expect_v("travel_tiro166", S_TIRO, 1); end
            167:  begin expect_v("bottom_tiro", S_TIRO, 0); expect_v("bottom_yb", S_YB, 476); end
            168:  begin expect_v("spawn2_tiro", S_TIRO, 1); expect_v("spawn2_xb", S_XB, 96);
                        expect_v("spawn2_yb", S_YB, 56); end
            170:  begin
                     expect_v("travel_yb170", S_YB, 64);
                     step(0, 0, 1);
                     expect_v("nave_tiro", S_TIRO, 0);
                     expect_v("nave_yb", S_YB, 64);
                  end
            228:  expect_v("cd_tiro228", S_TIRO, 0);
            229:  begin expect_v("spawn3_tiro", S_TIRO, 1); expect_v("spawn3_xb", S_XB, 128); end
            1208: begin expect_v("edge_x", S_X, 604); expect_v("edge_y", S_Y, 32); end
            1216: begin expect_v("bounce_x", S_X, 604); expect_v("bounce_y", S_Y, 48); end
            1224: begin expect_v("left_x", S_X, 600); expect_v("left_y", S_Y, 48); end
            default: ;
         endcase
      end

      // Kill on a step tick, second hit while dead, respawn
      step(1, 1, 0);
      expect_v("kill_x", S_X, 600); expect_v("kill_vivo", S_VIVO, 0); expect_v("kill_pts", S_PTS, 1);
      for (int i = 1; i <= 30; i++) begin
         step(1, 0, 0);
         if (i == 5) begin
            step(0, 1, 0);
            expect_v("dead_hit_pts", S_PTS, 1);
         end
         if (i == 29) begin expect_v("dead29_vivo", S_VIVO, 0); expect_v("dead29_x", S_X, 600); end
         if (i == 30) begin
            expect_v("resp_x", S_X, 0); expect_v("resp_y", S_Y, 32); expect_v("resp_vivo", S_VIVO, 1);
         end
      end
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 0);
         if (i == 7) expect_v("resp_x7", S_X, 0);
         if (i == 8) begin expect_v("resp_x8", S_X, 4); expect_v("resp_pts", S_PTS, 1); end
      end

      // Invasion from reset: 23 descents, the last at the right edge
      do_reset();
      expect_v("rst2_pts", S_PTS, 0); expect_v("rst2_x", S_X, 0); expect_v("rst2_vivo", S_VIVO, 1);
      step(0, 0, 0);
      reset = 1'b0;
      bus_if.ativo = 1'b1;
      step(0, 0, 0);
      for (int t = 1; t <= 27968; t++) begin
         step(1, 0, 0);
         if (t == 27967) begin
            expect_v("preinv_x", S_X, 604); expect_v("preinv_y", S_Y, 384); expect_v("preinv_inv", S_INV, 0);
         end
         if (t == 27968) begin
            expect_v("inv_y", S_Y, 400); expect_v("inv_flag", S_INV, 1); expect_v("inv_tiro", S_TIRO, 0);
         end
      end
      step(1, 1, 0);
      for (int i = 0; i < 15; i++) step(1, 0, 0);
      expect_v("post_inv_x", S_X, 604); expect_v("post_inv_y", S_Y, 400);
      expect_v("post_inv_flag", S_INV, 1); expect_v("post_inv_tiro", S_TIRO, 0);
      expect_v("post_inv_pts", S_PTS, 0); expect_v("post_inv_vivo", S_VIVO, 1);

      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL scoreboard_drain got=%0d want=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
